// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with a down-counting digit index,
// a double-buffered display value and a blanking window at the start of each slot.
module seg_scan_driver #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int CW           = $clog2(PRESCALE)
) (
  input  logic        clck,
  input  logic        reste,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        enable,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit,
  output logic        frame_done
);

  // PRESCALE=1 gives CW=0; keep at least one counter bit so the vector stays legal.
  localparam int CNT_W = (CW < 1) ? 1 : CW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      active_q, active_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  logic             en_q, en_d;
  logic             blz_q, blz_d;

  logic slot_end, frame_end;

  always_comb begin
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    en_d         = enable;
    blz_d        = blank_lz;

    slot_end  = enable && (cnt_q == CNT_LAST);
    frame_end = slot_end && (digit_q == 2'd0);

    if (!enable) begin
      cnt_d   = '0;
      digit_d = 2'd3;
    end else if (slot_end) begin
      cnt_d   = '0;
      digit_d = digit_q - 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A load coinciding with the frame boundary bypasses the shadow stage.
    if (frame_end) begin
      frame_done_d = 1'b1;
      pending_d    = 1'b0;
      if (load) begin
        active_d = value;
        shadow_d = value;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clck or posedge reste) begin
    if (reste) begin
      cnt_q        <= '0;
      digit_q      <= 2'd3;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      en_q         <= 1'b0;
      blz_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      en_q         <= en_d;
      blz_q        <= blz_d;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [3:0] nib;
  logic       in_blank, lead_zero, lit;

  always_comb begin
    nib = active_q[{digit_q, 2'b00} +: 4];
    case (digit_q)
      2'd3:    lead_zero = (active_q[15:12] == 4'h0);
      2'd2:    lead_zero = (active_q[15:8] == 8'h00);
      2'd1:    lead_zero = (active_q[15:4] == 12'h000);
      default: lead_zero = 1'b0;
    endcase
    in_blank = int'(cnt_q) < BLANK_CYCLES;
    // Everything here decodes registers only, so input glitches never reach the pins.
    lit = en_q && !in_blank && !(blz_q && lead_zero);
    an  = lit ? ~(4'b0001 << digit_q) : 4'b1111;
    seg = lit ? hex7(nib) : 7'b1111111;
  end

  assign dp         = 1'b1;
  assign digit      = digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a position-based display model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_seg_scan_driver;
  localparam int P = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * P;

  logic        clck = 1'b0;
  logic        reste = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit;
  logic        frame_done;

  seg_scan_driver #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clck(clck), .reste(reste), .value(value), .load(load), .enable(enable),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .digit(digit),
    .frame_done(frame_done)
  );

  always #5 clck = ~clck;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int         due;
    logic [3:0] an;
    logic [6:0] seg;
    bit         seg_chk;
    logic [1:0] digit;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clck) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  // Model state: position within the frame (0..4P-1) replaces separate counters.
  int          pos = 0;
  bit          m_en = 0, m_blz = 0, m_pend = 0, m_fd = 0;
  logic [15:0] m_sh = '0, m_act = '0;
  bit          en_in = 0, blz_in = 0, rst_prev = 1;

  function automatic int m_dig();
    return 3 - pos / P;
  endfunction
  function automatic int m_cnt();
    return pos % P;
  endfunction

  task automatic step(input bit r, input bit ld, input logic [15:0] v);
    exp_t e;
    bit   bnd, show, lit;
    int   d;
    reste = r; load = ld; value = v; enable = en_in; blank_lz = blz_in;
    if (r && !rst_prev) begin
      sb.delete();
      #1;
      cmp("async_rst_an", an, 4'hF);
      cmp("async_rst_seg", seg, 7'h7F);
      cmp("async_rst_digit", digit, 3);
    end
    rst_prev = r;
    if (r) begin
      pos = 0; m_en = 0; m_blz = 0; m_pend = 0; m_fd = 0; m_sh = '0; m_act = '0;
    end else begin
      bnd  = en_in && (pos == FRAME - 1);
      m_fd = bnd;
      if (bnd) begin
        if (ld) begin m_act = v; m_sh = v; end
        else if (m_pend) m_act = m_sh;
        m_pend = 0;
      end else if (ld) begin
        m_sh = v; m_pend = 1;
      end
      pos   = en_in ? (pos + 1) % FRAME : 0;
      m_en  = en_in;
      m_blz = blz_in;
    end
    d    = m_dig();
    show = m_en && (m_cnt() >= B);
    lit  = show && !(m_blz && d != 0 && (m_act >> (4 * d)) == 0);
    e.due     = cyc + 1;
    e.digit   = 2'(d);
    e.fd      = m_fd;
    e.an      = lit ? ~(4'b0001 << d) : 4'b1111;
    e.seg_chk = lit || !show;
    e.seg     = lit ? HEX[m_act[4*d +: 4]] : 7'b1111111;
    sb.push_back(e);
    @(posedge clck); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'($urandom));
  endtask

  task automatic run_until(input int dg, input int ct, input string name);
    int i;
    i = 0;
    while (!(m_dig() == dg && m_cnt() == ct) && i < 200) begin
      step(0, 0, 16'($urandom));
      i++;
    end
    cmp({"reach_", name}, (m_dig() == dg && m_cnt() == ct), 1);
  endtask

  always @(negedge clck) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        cmp("stale_entry", e.due, cyc);
      end else begin
        cmp("digit", digit, e.digit);
        cmp("frame_done", frame_done, e.fd);
        cmp("an", an, e.an);
        cmp("dp", dp, 1);
        if (e.seg_chk) cmp("seg", seg, e.seg);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clck); #1;
    step(1, 0, 16'h0); step(1, 0, 16'h0);
    en_in = 1;
    idle(45);
    // Asynchronous reset mid-run, then release with enable high.
    step(1, 0, 16'h0); step(1, 0, 16'h0);
    idle(12);
    // Scan order and load.
    step(0, 1, 16'h12AF);
    idle(80);
    // No tearing, with a second load in the same frame.
    step(0, 1, 16'h2222);
    idle(40);
    run_until(1, 3, "dig1");
    step(0, 1, 16'h1111);
    run_until(0, 1, "dig0");
    step(0, 1, 16'h3333);
    idle(70);
    // Load coinciding with the frame boundary.
    run_until(0, P - 1, "boundary");
    step(0, 1, 16'h00C0);
    idle(40);
    // Leading-zero suppression.
    blz_in = 1;
    step(0, 1, 16'h0005); idle(70);
    step(0, 1, 16'h0000); idle(70);
    blz_in = 0;
    idle(40);
    // Enable gating mid-slot; loads still land in the shadow.
    run_until(2, 5, "en_drop");
    en_in = 0;
    idle(3);
    step(0, 1, 16'hBEEF);
    idle(3);
    en_in = 1;
    idle(80);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      bit r, ld;
      r  = ($urandom_range(0, 499) == 0);
      ld = ($urandom_range(0, 9) == 0);
      if (en_in ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 3) == 0)) en_in = !en_in;
      if ($urandom_range(0, 99) == 0) blz_in = !blz_in;
      step(r, ld, 16'($urandom));
    end
    idle(5);
    @(negedge clck); #1;
    cmp("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
